arm_fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of arm_core. Generates sequential word fetches to instruction

---
 rtl/arm_fetch_unit_pkg.sv | 22 ++
 rtl/arm_fetch_queue.sv | 46 ++++
 rtl/arm_fetch_unit.sv | 99 +++++++++
 tb/tb_arm_fetch_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encodings and the prefetch queue entry layout.
package arm_fetch_unit_pkg;

    localparam logic [31:0] ARM_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_BOOT = 2'd0,
        FETCH_RUN  = 2'd1,
        FETCH_HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/arm_fetch_queue.sv
// Prefetch FIFO holding {pc, inst} pairs between memory and the core.
// Flush dominates push and pop; head reads as zero while empty.
module arm_fetch_queue
    import arm_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [CW-1:0] count_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + AW'(1);
            if (pop_i)  rd_q <= rd_q + AW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/arm_fetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch, prefetch
// queue to the core, redirect with stale-response discard, halt.
module arm_fetch_unit
    import arm_fetch_unit_pkg::*;
#(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = ARM_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_e  state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   resp_pc_q;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] discard_q;
    logic [CW-1:0] count;
    fetch_entry_t  head;

    logic credit_ok;
    logic xfer;
    logic rsp;
    logic drop;
    logic push;
    logic pop;

    assign credit_ok = ({1'b0, count} + {1'b0, inflight_q})
                       < (CW+1)'(QDEPTH);
    assign imem_req  = (state_q == FETCH_RUN) & ~halt
                       & ~redirect & credit_ok;
    assign imem_addr = fetch_pc_q[31:2];
    assign xfer      = imem_req & imem_ack;

    // Responses with nothing outstanding are ignored outright
    assign rsp  = imem_rvalid & (inflight_q != '0);
    assign drop = rsp & (discard_q != '0);
    assign push = rsp & ~drop & ~redirect;
    assign pop  = inst_valid & inst_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH_BOOT;
            fetch_pc_q <= word_align(RESET_PC);
            resp_pc_q  <= word_align(RESET_PC);
            inflight_q <= '0;
            discard_q  <= '0;
        end else if (redirect) begin
            fetch_pc_q <= word_align(redirect_pc);
            resp_pc_q  <= word_align(redirect_pc);
            inflight_q <= inflight_q - CW'(rsp);
            discard_q  <= inflight_q - CW'(rsp);
            state_q    <= halt ? FETCH_HALT : FETCH_RUN;
        end else begin
            if (xfer) fetch_pc_q <= fetch_pc_q + 32'd4;
            if (push) resp_pc_q  <= resp_pc_q + 32'd4;
            if (drop) discard_q  <= discard_q - CW'(1);
            inflight_q <= inflight_q + CW'(xfer) - CW'(rsp);
            unique case (state_q)
                FETCH_BOOT: state_q <= FETCH_RUN;
                FETCH_RUN:  if (halt) state_q <= FETCH_HALT;
                FETCH_HALT: state_q <= FETCH_HALT;
                default:    state_q <= FETCH_BOOT;
            endcase
        end
    end

    arm_fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (redirect),
        .push_i     (push),
        .push_data_i('{pc: resp_pc_q, inst: imem_rdata}),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count)
    );

    assign inst       = head.inst;
    assign inst_pc    = head.pc;
    assign inst_valid = (count != '0);

endmodule

// File: tb/tb_arm_fetch_unit.sv
// Directed bench for arm_fetch_unit with an in-order memory model.
// Delivered words are recorded and checked against PC-derived data.
module tb_arm_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    logic        rsp_hold;
    int          nxfer = 0;
    logic [29:0] pend [$];
    logic [31:0] got_pc [$];
    logic [31:0] got_in [$];
    int          checks = 0;
    int          errors = 0;
    int          base;
    int          x0;

    arm_fetch_unit #(
        .QDEPTH  (4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [29:0] a);
        return {a, 2'b11} ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_got(input int n);
        int k;
        k = 0;
        while (got_pc.size() < n && k < 60) begin
            tick(1);
            k++;
        end
        if (got_pc.size() < n) check("timeout", got_pc.size(), n);
    endtask

    task automatic check_got(input string tag, input int idx,
                             input logic [31:0] pc);
        if (idx < got_pc.size()) begin
            check({tag, "_pc"}, got_pc[idx], pc);
            check({tag, "_in"}, got_in[idx], dat(pc[31:2]));
        end
    endtask

    // Memory: accept on transfer, answer in order one cycle later
    always begin
        @(posedge clk);
        if (rst) begin
            pend.delete();
        end else if (imem_req && imem_ack) begin
            pend.push_back(imem_addr);
            nxfer++;
        end
        @(negedge clk);
        if (!rsp_hold && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = dat(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    always @(posedge clk) begin
        if (!rst && inst_valid && inst_ready && !redirect) begin
            got_pc.push_back(inst_pc);
            got_in.push_back(inst);
        end
    end

    initial begin
        rst = 1'b1;
        imem_ack = 1'b1;
        inst_ready = 1'b1;
        halt = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        rsp_hold = 1'b0;
        tick(2);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_val", inst_valid, 0);
        check("rst_inst", inst, 0);
        check("rst_pc", inst_pc, 0);

        // sequential stream
        rst = 1'b0;
        base = got_pc.size();
        tick(1);
        check("t1_req", imem_req, 1);
        check("t1_a0", imem_addr, 0);
        check("t1_v1", inst_valid, 0);
        tick(1);
        check("t1_a1", imem_addr, 1);
        check("t1_v2", inst_valid, 0);
        tick(1);
        check("t1_v3", inst_valid, 1);
        check("t1_pc", inst_pc, 0);
        check("t1_in", inst, dat(30'h0));
        wait_got(base + 4);
        for (int i = 0; i < 4; i++) begin
            check_got("t1", base + i, 32'(4 * i));
        end

        // credit limit with a stalled core
        rst = 1'b1;
        inst_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        x0 = nxfer;
        tick(12);
        check("t2_nx", nxfer - x0, 4);
        check("t2_req", imem_req, 0);
        check("t2_val", inst_valid, 1);
        check("t2_pc", inst_pc, 0);
        base = got_pc.size();
        inst_ready = 1'b1;
        tick(1);
        inst_ready = 1'b0;
        #1;
        check("t2_req1", imem_req, 1);
        check("t2_pc1", inst_pc, 4);
        check("t2_pop", got_pc.size() - base, 1);
        tick(4);
        check("t2_nx5", nxfer - x0, 5);
        check("t2_req0", imem_req, 0);

        // redirect with rvalid and pop in the same cycle
        rsp_hold = 1'b1;
        inst_ready = 1'b1;
        base = got_pc.size();
        tick(3);
        check("t4_req", imem_req, 1);
        check("t4_head", inst_pc, 16);
        rsp_hold = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0300;
        #1;
        check("t4_noreq", imem_req, 0);
        tick(1);
        redirect = 1'b0;
        #1;
        check("t4_val", inst_valid, 0);
        check("t4_addr", imem_addr, 30'hC0);
        check("t4_req1", imem_req, 1);
        check("t4_pops", got_pc.size() - base, 3);
        base = got_pc.size();
        wait_got(base + 2);
        check_got("t4_w0", base, 32'h300);
        check_got("t4_w1", base + 1, 32'h304);

        // redirect with two stale requests in flight
        rst = 1'b1;
        rsp_hold = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        imem_ack = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        #1;
        check("t3_noreq", imem_req, 0);
        base = got_pc.size();
        tick(1);
        redirect = 1'b0;
        imem_ack = 1'b1;
        rsp_hold = 1'b0;
        #1;
        check("t3_addr", imem_addr, 30'h40);
        check("t3_req", imem_req, 1);
        wait_got(base + 2);
        check_got("t3_w0", base, 32'h100);
        check_got("t3_w1", base + 1, 32'h104);

        // halt with three in flight
        rst = 1'b1;
        rsp_hold = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
        halt = 1'b1;
        #1;
        check("t5_noreq", imem_req, 0);
        x0 = nxfer;
        base = got_pc.size();
        rsp_hold = 1'b0;
        tick(8);
        check("t5_nx", nxfer - x0, 0);
        check("t5_got", got_pc.size() - base, 3);
        check_got("t5_w2", base + 2, 32'h8);
        halt = 1'b0;
        #1;
        check("t5_halted", imem_req, 0);
        tick(3);
        check("t5_nx2", nxfer - x0, 0);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0400;
        tick(1);
        redirect = 1'b0;
        #1;
        check("t5_run", imem_req, 1);
        check("t5_addr", imem_addr, 30'h100);

        // address wrap, then reset mid-stream
        tick(2);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick(1);
        redirect = 1'b0;
        rsp_hold = 1'b1;
        #1;
        check("t6_amax", imem_addr, 30'h3FFF_FFFF);
        check("t6_req", imem_req, 1);
        tick(1);
        check("t6_wrap", imem_addr, 0);
        tick(1);
        check("t6_req2", imem_req, 1);
        rst = 1'b1;
        tick(1);
        check("t6_rreq", imem_req, 0);
        check("t6_raddr", imem_addr, 0);
        check("t6_rval", inst_valid, 0);
        check("t6_rinst", inst, 0);
        check("t6_rpc", inst_pc, 0);
        rst = 1'b0;
        rsp_hold = 1'b0;
        tick(1);
        check("t6_req3", imem_req, 1);
        check("t6_addr3", imem_addr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
